riscv_wb_checker: RTL and testbench
===================================

// Module: riscv_wb_checker
// PURPOSE
//  Synthesizable, parametrised self-checking monitor for the processor's write-back stream (WB_Data).
//  - Holds a table of expected write-back values and counts cycles.
//  - Compares every valid write-back against the table in order.
//  - Reports pass/fail, the first failing entry and timeout.
//  - Sits beside the riscv top on the write-back bus; usable in simulation benches and on FPGA.
// PARAMETERS
//  DATA_W      32   width of write-back data
//  DEPTH       64   max expected entries; AW = $clog2(DEPTH)
//  TIMEOUT_CYC 65   RUN cycles allowed before timeout fail; must be >= 1
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  wb_valid     in   1       write-back data valid this cycle
//  wb_data      in   DATA_W  write-back value
//  exp_wr_en    in   1       expected-table write strobe (IDLE only)
//  exp_wr_addr  in   AW      expected-table write address
//  exp_wr_data  in   DATA_W  expected-table write data
//  exp_count    in   AW+1    entries to check (0..DEPTH), sampled on start
//  start        in   1       begin a check run
//  busy         out  1       state==RUN
//  done         out  1       state==PASS or FAIL
//  pass         out  1       state==PASS
//  err_code     out  2       0 none, 1 mismatch, 2 timeout
//  err_index    out  AW      table index of first failure
//  err_got      out  DATA_W  wb_data at first mismatch
//  err_exp      out  DATA_W  expected value at first mismatch
//  err_total    out  AW+1    mismatch count (see CONFIGURATION)
//  cycle_count  out  32      RUN cycles elapsed, frozen in PASS/FAIL
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0.
//  - Table: DEPTH x DATA_W. Not cleared by reset. Async (combinational) read.
//  - exp_wr_en is honoured only in IDLE; ignored in all other states.
//  - FSM IDLE->RUN: on start with exp_count>0. Registers n=exp_count; clears idx, cycle_count and err_*.
//  - FSM IDLE->PASS: on start with exp_count==0 (next cycle).
//  - FSM RUN:
//    - cycle_count increments by 1 each cycle.
//    - On wb_valid, compare wb_data with table[idx] in the same cycle.
//    - Match: idx++. If idx==n-1 -> PASS.
//    - Mismatch -> FAIL; err_code=1; capture err_index=idx, err_got, err_exp.
//  - Timeout: cycle_count==TIMEOUT_CYC-1 with no terminal event -> FAIL, err_code=2, err_index=idx.
//  - Simultaneous final match and timeout -> PASS wins. Simultaneous mismatch and timeout -> err_code=1.
//  - PASS/FAIL are sticky. start re-enters RUN (or PASS if exp_count==0); start in RUN is ignored.
//  - Outputs are registered and change the cycle after the deciding edge.
//  - wb_valid outside RUN is ignored.
//  - Reset mid-RUN -> IDLE, no report; table contents retained.
//  - idx never exceeds n-1 (no wrap); exp_count>DEPTH is clamped to DEPTH.
// CONFIGURATION
//  WBCHK_CONT_EN defined:
//    - A mismatch does not stop RUN; err_total++ and idx++.
//    - err_* capture the first mismatch only.
//    - After entry n-1 has been checked: PASS if err_total==0, else FAIL with err_code=1.
//    - Timeout behaviour is unchanged.
//  WBCHK_CONT_EN undefined:
//    - Stop at first mismatch.
//    - err_total is 1 after a mismatch fail, else 0.
// TESTING
//  - Load {1,2,3}, exp_count=3, start; wb 1,2,3 valid on consecutive cycles
//    -> pass=1, done=1, err_code=0, cycle_count=3.
//  - Load {0xA,0xB}; wb 0xA then 0xC -> FAIL, err_code=1, err_index=1, err_got=0xC, err_exp=0xB.
//    With CONT_EN: err_total=1.
//  - exp_count=4, only 2 valid wb, TIMEOUT_CYC=65 -> FAIL at cycle_count=65, err_code=2, err_index=2.
//  - Final match on the timeout cycle -> pass=1; reset asserted mid-RUN
//    -> IDLE, outputs 0; restart with same table -> pass.
//  - exp_count=0, start -> pass next cycle. exp_wr_en during RUN does not alter the table
//    (verify by rerun). start during RUN ignored.
//  - CONT_EN: {5,6,7} vs wb 5,0,0 -> FAIL after 3rd wb, err_total=2, err_index=1.

Source files
------------

// File: rtl/riscv_wb_checker.sv
// riscv_wb_checker: self-checking monitor for the processor write-back stream.
// A table of expected write-back values is loaded while idle. A check run then
// compares every valid write-back against the table in order. The run ends with
// pass, the first mismatch, or a timeout. The result stays visible until the
// next start or reset.
//
// Optional build macro WBCHK_CONT_EN: a mismatch does not end the run. The
// checker keeps counting mismatches until the last entry has been checked.
// Without the macro, the run stops at the first mismatch.
//
// DEPTH must be at least 2 so that the table index has a non-zero width.
module riscv_wb_checker #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int TIMEOUT_CYC = 65,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              exp_wr_en,
    input  logic [AW-1:0]     exp_wr_addr,
    input  logic [DATA_W-1:0] exp_wr_data,
    input  logic [AW:0]       exp_count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        err_code,
    output logic [AW-1:0]     err_index,
    output logic [DATA_W-1:0] err_got,
    output logic [DATA_W-1:0] err_exp,
    output logic [AW:0]       err_total,
    output logic [31:0]       cycle_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } state_t;

    localparam logic [AW:0]   DEPTH_LIM    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_N        = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_IDX      = AW'(1);
    localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd2;

    state_t            state;
    logic [DATA_W-1:0] exp_table [DEPTH];
    logic [AW-1:0]     idx;
    logic [AW:0]       n_entries;

    logic [AW:0]       count_clamped;
    logic [DATA_W-1:0] cur_exp;
    logic              mismatch;
    logic              is_last;
    logic              timeout_hit;
    logic [AW-1:0]     idx_inc;
    logic [AW:0]       total_inc;

    // Derive the per-cycle compare and terminal conditions.
    // The table read is combinational, so the compare happens in the same
    // cycle that wb_valid is seen.
    always_comb begin
        count_clamped = (exp_count > DEPTH_LIM) ? DEPTH_LIM : exp_count;
        cur_exp       = exp_table[idx];
        mismatch      = wb_valid && (wb_data != cur_exp);
        is_last       = ({1'b0, idx} == (n_entries - ONE_N));
        timeout_hit   = (cycle_count == TIMEOUT_LAST);
        idx_inc       = idx + ONE_IDX;
        total_inc     = err_total + ONE_N;
    end

    // Load the expected table.
    // Writes are accepted only while idle, so a running check never sees its
    // reference change. Reset does not clear the table, so a bench can rerun
    // the same table after aborting a run.
    always_ff @(posedge clk) begin
        if (exp_wr_en && (state == IDLE) && ({1'b0, exp_wr_addr} < DEPTH_LIM)) begin
            exp_table[exp_wr_addr] <= exp_wr_data;
        end
    end

    // Check-run sequencer and its registered report.
    // This block holds the state, the run bookkeeping and every output, so
    // the outputs change one cycle after the edge that decides them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_code    <= CODE_NONE;
            err_index   <= '0;
            err_got     <= '0;
            err_exp     <= '0;
            err_total   <= '0;
            cycle_count <= '0;
            idx         <= '0;
            n_entries   <= '0;
        end else begin
            case (state)
                RUN: begin
                    cycle_count <= cycle_count + 32'd1;
`ifdef WBCHK_CONT_EN
                    if (mismatch) begin
                        err_total <= total_inc;
                        if (err_total == '0) begin
                            err_index <= idx;
                            err_got   <= wb_data;
                            err_exp   <= cur_exp;
                        end
                    end
                    if (wb_valid && is_last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        if (mismatch || (err_total != '0)) begin
                            state    <= FAIL;
                            err_code <= CODE_MISMATCH;
                        end else begin
                            state <= PASS;
                            pass  <= 1'b1;
                        end
                    end else begin
                        if (wb_valid) begin
                            idx <= idx_inc;
                        end
                        if (timeout_hit) begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            if (mismatch) begin
                                err_code <= CODE_MISMATCH;
                            end else begin
                                err_code  <= CODE_TIMEOUT;
                                err_index <= wb_valid ? idx_inc : idx;
                            end
                        end
                    end
`else
                    if (mismatch) begin
                        state     <= FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        err_code  <= CODE_MISMATCH;
                        err_index <= idx;
                        err_got   <= wb_data;
                        err_exp   <= cur_exp;
                        err_total <= ONE_N;
                    end else if (wb_valid && is_last) begin
                        state <= PASS;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        if (wb_valid) begin
                            idx <= idx_inc;
                        end
                        if (timeout_hit) begin
                            state     <= FAIL;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            err_code  <= CODE_TIMEOUT;
                            err_index <= wb_valid ? idx_inc : idx;
                        end
                    end
`endif
                end
                default: begin
                    if (start) begin
                        n_entries   <= count_clamped;
                        idx         <= '0;
                        cycle_count <= '0;
                        err_code    <= CODE_NONE;
                        err_index   <= '0;
                        err_got     <= '0;
                        err_exp     <= '0;
                        err_total   <= '0;
                        if (count_clamped == '0) begin
                            state <= PASS;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_wb_checker.sv
// tb_riscv_wb_checker: scoreboard bench for riscv_wb_checker.
// The stimulus side computes each run's expected report with a cycle-by-cycle
// reference model and queues it. A monitor pops and compares an entry each
// time the checker presents a finished report.
module tb_riscv_wb_checker;

    localparam int DATA_W      = 32;
    localparam int DEPTH       = 64;
    localparam int AW          = 6;
    localparam int TIMEOUT_CYC = 65;
    localparam int SCHED_LEN   = 80;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic              exp_wr_en;
    logic [AW-1:0]     exp_wr_addr;
    logic [DATA_W-1:0] exp_wr_data;
    logic [AW:0]       exp_count;
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [1:0]        err_code;
    logic [AW-1:0]     err_index;
    logic [DATA_W-1:0] err_got;
    logic [DATA_W-1:0] err_exp;
    logic [AW:0]       err_total;
    logic [31:0]       cycle_count;

    typedef struct packed {
        logic              pass;
        logic [1:0]        code;
        logic [AW-1:0]     index;
        logic [DATA_W-1:0] got;
        logic [DATA_W-1:0] exp_v;
        logic [AW:0]       total;
        logic [31:0]       cycles;
    } result_t;

    result_t           exp_q [$];
    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] tbl_model [DEPTH];
    logic              sched_valid [SCHED_LEN];
    logic [DATA_W-1:0] sched_data [SCHED_LEN];

    riscv_wb_checker #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .exp_wr_en  (exp_wr_en),
        .exp_wr_addr(exp_wr_addr),
        .exp_wr_data(exp_wr_data),
        .exp_count  (exp_count),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_code   (err_code),
        .err_index  (err_index),
        .err_got    (err_got),
        .err_exp    (err_exp),
        .err_total  (err_total),
        .cycle_count(cycle_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference model: walk the run cycle by cycle, checking entries in order.
    function automatic result_t model_run(input int count);
        result_t r;
        int n, checked, mism, hit;
        r = '0;
        n = (count > DEPTH) ? DEPTH : count;
        if (n == 0) begin
            r.pass = 1'b1;
            return r;
        end
        checked = 0;
        mism = 0;
        for (int c = 1; c <= TIMEOUT_CYC; c++) begin
            hit = 0;
            r.cycles = 32'(c);
            if (sched_valid[c-1]) begin
                if (sched_data[c-1] !== tbl_model[checked]) begin
                    hit = 1;
                    mism++;
                    if (mism == 1) begin
                        r.index = AW'(checked);
                        r.got   = sched_data[c-1];
                        r.exp_v = tbl_model[checked];
                    end
`ifndef WBCHK_CONT_EN
                    r.code  = 2'd1;
                    r.total = (AW+1)'(1);
                    return r;
`endif
                end
                checked++;
                if (checked == n) begin
                    r.total = (AW+1)'(mism);
                    if (mism == 0) r.pass = 1'b1;
                    else r.code = 2'd1;
                    return r;
                end
            end
            if (c == TIMEOUT_CYC) begin
                r.total = (AW+1)'(mism);
                if (hit != 0) begin
                    r.code = 2'd1;
                end else begin
                    r.code  = 2'd2;
                    r.index = AW'(checked);
                end
                return r;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        wb_valid    = 1'b0;
        wb_data     = '0;
        exp_wr_en   = 1'b0;
        exp_wr_addr = '0;
        exp_wr_data = '0;
        start       = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        idleInputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic loadTable(input int count);
        for (int i = 0; i < count; i++) begin
            exp_wr_en   = 1'b1;
            exp_wr_addr = AW'(i);
            exp_wr_data = tbl_model[i];
            tick();
        end
        exp_wr_en = 1'b0;
    endtask

    task automatic clearSched();
        for (int i = 0; i < SCHED_LEN; i++) begin
            sched_valid[i] = 1'b0;
            sched_data[i]  = '0;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_pass"}, 64'(pass), 64'd0);
        checkOutput({tag, "_err_code"}, 64'(err_code), 64'd0);
        checkOutput({tag, "_err_index"}, 64'(err_index), 64'd0);
        checkOutput({tag, "_err_got"}, 64'(err_got), 64'd0);
        checkOutput({tag, "_err_exp"}, 64'(err_exp), 64'd0);
        checkOutput({tag, "_err_total"}, 64'(err_total), 64'd0);
        checkOutput({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
    endtask

    // One check run: queue the expected report, start, play the schedule.
    // start_mid / wr_mid pulse a start or a table write during RUN; both must
    // be ignored by the checker.
    task automatic applyStimulus(input int count, input int start_mid, input int wr_mid);
        exp_q.push_back(model_run(count));
        exp_count = (AW+1)'(count);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < SCHED_LEN && !done; c++) begin
            wb_valid    = sched_valid[c];
            wb_data     = sched_data[c];
            start       = (c == start_mid);
            exp_wr_en   = (c == wr_mid);
            exp_wr_addr = '0;
            exp_wr_data = 32'hDEAD_BEEF;
            tick();
        end
        idleInputs();
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL run_terminate: done=%0b, required 1 within %0d cycles", done, SCHED_LEN);
        end
        tick();
    endtask

    // Monitor: compare a report whenever a run has just finished.
    initial begin : monitor
        result_t e;
        logic done_prev, start_edge, reset_edge;
        done_prev = 1'b0;
        forever begin
            @(posedge clk);
            start_edge = start;
            reset_edge = reset;
            @(negedge clk);
            if (!reset_edge && done && (!done_prev || start_edge)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_report: got a report, required none queued");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pass", 64'(pass), 64'(e.pass));
                    checkOutput("err_code", 64'(err_code), 64'(e.code));
                    checkOutput("err_index", 64'(err_index), 64'(e.index));
                    checkOutput("err_got", 64'(err_got), 64'(e.got));
                    checkOutput("err_exp", 64'(err_exp), 64'(e.exp_v));
                    checkOutput("err_total", 64'(err_total), 64'(e.total));
                    checkOutput("cycle_count", 64'(cycle_count), 64'(e.cycles));
                    checkOutput("busy_at_report", 64'(busy), 64'd0);
                end
            end
            done_prev = done;
        end
    end

    // Main stimulus sequence: directed cases first, then randomized runs.
    initial begin : stimulus
        int n, prob, nxt;
        exp_count = '0;
        doReset();
        checkAllZero("reset");

        // In-order pass, then reruns with ignored start/write during RUN.
        tbl_model[0] = 32'd1; tbl_model[1] = 32'd2; tbl_model[2] = 32'd3;
        loadTable(3);
        clearSched();
        for (int i = 0; i < 3; i++) begin
            sched_valid[i] = 1'b1;
            sched_data[i]  = tbl_model[i];
        end
        applyStimulus(3, -1, -1);
        applyStimulus(3, 1, 0);
        applyStimulus(3, -1, -1);

        // Mismatch on the second entry.
        doReset();
        tbl_model[0] = 32'hA; tbl_model[1] = 32'hB;
        loadTable(2);
        clearSched();
        sched_valid[0] = 1'b1; sched_data[0] = 32'hA;
        sched_valid[1] = 1'b1; sched_data[1] = 32'hC;
        applyStimulus(2, -1, -1);

        // Timeout with two of four entries seen, then mismatch on the timeout cycle.
        doReset();
        for (int i = 0; i < 4; i++) tbl_model[i] = 32'(i + 1);
        loadTable(4);
        clearSched();
        sched_valid[0] = 1'b1; sched_data[0] = 32'd1;
        sched_valid[1] = 1'b1; sched_data[1] = 32'd2;
        applyStimulus(4, -1, -1);
        clearSched();
        sched_valid[0]  = 1'b1; sched_data[0]  = 32'd1;
        sched_valid[64] = 1'b1; sched_data[64] = 32'd99;
        applyStimulus(3, -1, -1);

        // Final match on the timeout cycle wins.
        doReset();
        tbl_model[0] = 32'd1; tbl_model[1] = 32'd2;
        loadTable(2);
        clearSched();
        sched_valid[0]  = 1'b1; sched_data[0]  = 32'd1;
        sched_valid[64] = 1'b1; sched_data[64] = 32'd2;
        applyStimulus(2, -1, -1);

        // Reset in the middle of a run, then rerun on the retained table.
        exp_count = (AW+1)'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        wb_valid = 1'b1; wb_data = 32'd1;
        tick();
        wb_valid = 1'b0;
        tick();
        checkOutput("mid_run_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkAllZero("mid_reset");
        clearSched();
        sched_valid[0] = 1'b1; sched_data[0] = 32'd1;
        sched_valid[1] = 1'b1; sched_data[1] = 32'd2;
        applyStimulus(2, -1, -1);

        // Empty run passes on the next cycle.
        applyStimulus(0, -1, -1);

        // exp_count above DEPTH is clamped.
        doReset();
        for (int i = 0; i < DEPTH; i++) tbl_model[i] = 32'(i * 3 + 7);
        loadTable(DEPTH);
        clearSched();
        for (int i = 0; i < DEPTH; i++) begin
            sched_valid[i] = 1'b1;
            sched_data[i]  = tbl_model[i];
        end
        applyStimulus(100, -1, -1);

        // Randomized runs.
        for (int it = 0; it < 24; it++) begin
            doReset();
            n = $urandom_range(0, 8);
            for (int i = 0; i < 8; i++) tbl_model[i] = $urandom();
            loadTable(8);
            case ($urandom_range(0, 3))
                0: prob = 5;
                1: prob = 30;
                2: prob = 70;
                default: prob = 100;
            endcase
            nxt = 0;
            clearSched();
            for (int c = 0; c < SCHED_LEN; c++) begin
                sched_valid[c] = ($urandom_range(0, 99) < prob);
                if (sched_valid[c]) begin
                    if ($urandom_range(0, 9) == 0) begin
                        sched_data[c] = $urandom();
                    end else begin
                        sched_data[c] = tbl_model[nxt % 8];
                        nxt++;
                    end
                end
            end
            applyStimulus(n, int'($urandom_range(0, 10)), -1);
            applyStimulus(n, -1, int'($urandom_range(0, 10)));
        end

        tick();
        tick();
        tick();
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
